// File: rtl/m2_block_scheduler_if.sv
// Handshake and address bundle between the milestone-2 block scheduler
// and its neighbours (compute control upstream, SRAM writer downstream).
// The master modport is the scheduler; the slave modport is the environment.
interface m2_block_scheduler_if;
    logic        Enable;
    logic        Block_ready;
    logic        Block_taken;
    logic        Write_start;
    logic        Write_done;
    logic [17:0] Base_address;
    logic [8:0]  Jump_offset;
    logic [1:0]  Plane;
    logic [4:0]  Block_row;
    logic [5:0]  Block_col;
    logic        Busy;
    logic        Frame_done;

    modport master (
        input  Enable, Block_ready, Write_done,
        output Block_taken, Write_start, Base_address, Jump_offset,
               Plane, Block_row, Block_col, Busy, Frame_done
    );

    modport slave (
        output Enable, Block_ready, Write_done,
        input  Block_taken, Write_start, Base_address, Jump_offset,
               Plane, Block_row, Block_col, Busy, Frame_done
    );
endinterface

// File: rtl/m2_block_scheduler.sv
// Frame-level sequencer for the milestone-2 write-back stage.
// Walks all 8x8 blocks of Y, then U, then V in raster order (column fastest),
// hands each one to the SRAM writer with a one-cycle start pulse, waits for
// the writer's done pulse and then releases the upstream S buffer.
// Block base addresses are built incrementally (adds only, no multiplier).
module m2_block_scheduler #(
    parameter logic [17:0] Y_BASE       = 18'd0,
    parameter logic [17:0] U_BASE       = 18'd38400,
    parameter logic [17:0] V_BASE       = 18'd57600,
    parameter int          Y_COLS       = 40,
    parameter int          UV_COLS      = 20,
    parameter int          ROWS         = 30,
    parameter int          Y_ROW_WORDS  = 160,
    parameter int          UV_ROW_WORDS = 80
) (
    input  logic                   CLOCK_50,
    input  logic                   Reset,
    m2_block_scheduler_if.master   bus
);

    localparam logic [4:0] LAST_ROW    = 5'(ROWS - 1);
    localparam logic [5:0] Y_LAST_COL  = 6'(Y_COLS - 1);
    localparam logic [5:0] UV_LAST_COL = 6'(UV_COLS - 1);
    localparam logic [8:0] Y_JUMP      = 9'(Y_ROW_WORDS);
    localparam logic [8:0] UV_JUMP     = 9'(UV_ROW_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BLK,
        S_WAIT_DONE,
        S_ADVANCE,
        S_FINISH
    } state_t;

    state_t      r_state,        w_state_next;
    logic [1:0]  r_plane,        w_plane_next;
    logic [4:0]  r_row,          w_row_next;
    logic [5:0]  r_col,          w_col_next;
    logic [17:0] r_row_base,     w_row_base_next;
    logic [17:0] r_base,         w_base_next;
    logic [8:0]  r_jump,         w_jump_next;
    logic        r_busy,         w_busy_next;
    logic        r_write_start,  w_write_start_next;
    logic        r_block_taken,  w_block_taken_next;
    logic        r_frame_done,   w_frame_done_next;

    // Helpers derived from the current plane: last column, the 8-pixel-row
    // stride of one block row, and where the following plane starts.
    logic [5:0]  w_last_col;
    logic [17:0] w_block_row_stride;
    logic [17:0] w_row_base_incr;
    logic [17:0] w_next_plane_base;

    assign w_last_col         = (r_plane == 2'd0) ? Y_LAST_COL : UV_LAST_COL;
    assign w_block_row_stride = 18'({r_jump, 3'b000});
    assign w_row_base_incr    = r_row_base + w_block_row_stride;
    assign w_next_plane_base  = (r_plane == 2'd0) ? U_BASE : V_BASE;

    // State and all output registers; reset aborts any frame in progress.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_plane       <= 2'd0;
            r_row         <= 5'd0;
            r_col         <= 6'd0;
            r_row_base    <= Y_BASE;
            r_base        <= Y_BASE;
            r_jump        <= Y_JUMP;
            r_busy        <= 1'b0;
            r_write_start <= 1'b0;
            r_block_taken <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_plane       <= w_plane_next;
            r_row         <= w_row_next;
            r_col         <= w_col_next;
            r_row_base    <= w_row_base_next;
            r_base        <= w_base_next;
            r_jump        <= w_jump_next;
            r_busy        <= w_busy_next;
            r_write_start <= w_write_start_next;
            r_block_taken <= w_block_taken_next;
            r_frame_done  <= w_frame_done_next;
        end
    end

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        w_state_next       = r_state;
        w_plane_next       = r_plane;
        w_row_next         = r_row;
        w_col_next         = r_col;
        w_row_base_next    = r_row_base;
        w_base_next        = r_base;
        w_jump_next        = r_jump;
        w_busy_next        = r_busy;
        w_write_start_next = 1'b0;
        w_block_taken_next = 1'b0;
        w_frame_done_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.Enable) begin
                    w_plane_next    = 2'd0;
                    w_row_next      = 5'd0;
                    w_col_next      = 6'd0;
                    w_row_base_next = Y_BASE;
                    w_base_next     = Y_BASE;
                    w_jump_next     = Y_JUMP;
                    w_busy_next     = 1'b1;
                    w_state_next    = S_WAIT_BLK;
                end
            end

            S_WAIT_BLK: begin
                if (bus.Block_ready) begin
                    w_write_start_next = 1'b1;
                    w_state_next       = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                // A done coinciding with our own start pulse is a writer fault.
                if (bus.Write_done && !r_write_start) begin
                    w_block_taken_next = 1'b1;
                    w_state_next       = S_ADVANCE;
                end
            end

            S_ADVANCE: begin
                w_state_next = S_WAIT_BLK;
                if (r_col != w_last_col) begin
                    w_col_next  = r_col + 6'd1;
                    w_base_next = r_base + 18'd4;
                end else if (r_row != LAST_ROW) begin
                    w_col_next      = 6'd0;
                    w_row_next      = r_row + 5'd1;
                    w_row_base_next = w_row_base_incr;
                    w_base_next     = w_row_base_incr;
                end else if (r_plane == 2'd2) begin
                    w_state_next = S_FINISH;
                end else begin
                    w_plane_next    = r_plane + 2'd1;
                    w_row_next      = 5'd0;
                    w_col_next      = 6'd0;
                    w_row_base_next = w_next_plane_base;
                    w_base_next     = w_next_plane_base;
                    w_jump_next     = UV_JUMP;
                end
            end

            S_FINISH: begin
                w_frame_done_next = 1'b1;
                w_busy_next       = 1'b0;
                w_state_next      = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.Block_taken  = r_block_taken;
    assign bus.Write_start  = r_write_start;
    assign bus.Base_address = r_base;
    assign bus.Jump_offset  = r_jump;
    assign bus.Plane        = r_plane;
    assign bus.Block_row    = r_row;
    assign bus.Block_col    = r_col;
    assign bus.Busy         = r_busy;
    assign bus.Frame_done   = r_frame_done;

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Bench for m2_block_scheduler: directed frames with a 10-cycle writer model,
// expected block descriptors queued up front and checked by a monitor on
// every Write_start.
module tb_m2_block_scheduler;

    typedef struct {
        int base;
        int jump;
        int plane;
        int row;
        int col;
    } exp_t;

    logic CLOCK_50;
    logic Reset;
    logic wd_model;
    logic wd_spur;
    logic writer_on;

    int checks   = 0;
    int failures = 0;
    int starts   = 0;
    int takens   = 0;
    int frames   = 0;
    int fidx     = 0;
    int wr_cnt   = 0;

    exp_t exp_q[$];

    // Hand-computed checkpoints within a frame: start index, base, jump.
    int d_idx  [7] = '{0, 1, 40, 1199, 1200, 1220, 2399};
    int d_base [7] = '{0, 4, 1280, 37276, 38400, 39040, 76236};
    int d_jump [7] = '{160, 160, 160, 160, 80, 80, 80};

    m2_block_scheduler_if bus();

    assign bus.Write_done = wd_model | wd_spur;

    m2_block_scheduler dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_frame();
        int pb;
        int rw;
        int nc;
        exp_t e;
        exp_q.delete();
        for (int p = 0; p < 3; p++) begin
            pb = (p == 0) ? 0 : ((p == 1) ? 38400 : 57600);
            rw = (p == 0) ? 160 : 80;
            nc = (p == 0) ? 40 : 20;
            for (int r = 0; r < 30; r++) begin
                for (int c = 0; c < nc; c++) begin
                    e.base  = pb + r * 8 * rw + c * 4;
                    e.jump  = rw;
                    e.plane = p;
                    e.row   = r;
                    e.col   = c;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Writer model: Done pulse 10 cycles after each observed Start.
    initial begin
        wd_model = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            wd_model = 1'b0;
            if (!writer_on) begin
                wr_cnt = 0;
            end else begin
                if (wr_cnt != 0) begin
                    wr_cnt--;
                    if (wr_cnt == 0) wd_model = 1'b1;
                end
                if (bus.Write_start) wr_cnt = 10;
            end
        end
    end

    // Monitor: pops one expectation per Write_start and checks that the
    // address pair is held until the block is acknowledged.
    initial begin
        exp_t e;
        logic in_write;
        logic stable;
        int   cap_base;
        int   cap_jump;
        in_write = 1'b0;
        stable   = 1'b1;
        cap_base = 0;
        cap_jump = 0;
        forever begin
            @(negedge CLOCK_50);
            if (Reset) begin
                in_write = 1'b0;
            end else begin
                if (bus.Write_start) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_start actual=%0d required=none", bus.Base_address);
                    end else begin
                        e = exp_q.pop_front();
                        chk("blk_base", int'(bus.Base_address), e.base);
                        chk("blk_jump", int'(bus.Jump_offset), e.jump);
                        chk("blk_pos", int'(bus.Plane) * 4096 + int'(bus.Block_row) * 64 + int'(bus.Block_col),
                            e.plane * 4096 + e.row * 64 + e.col);
                    end
                    for (int k = 0; k < 7; k++) begin
                        if (fidx == d_idx[k]) begin
                            chk("dir_base", int'(bus.Base_address), d_base[k]);
                            chk("dir_jump", int'(bus.Jump_offset), d_jump[k]);
                        end
                    end
                    $display("blk %0d plane=%0d row=%0d col=%0d base=%0d jump=%0d",
                             fidx, bus.Plane, bus.Block_row, bus.Block_col,
                             bus.Base_address, bus.Jump_offset);
                    fidx++;
                    starts++;
                    in_write = 1'b1;
                    stable   = 1'b1;
                    cap_base = int'(bus.Base_address);
                    cap_jump = int'(bus.Jump_offset);
                end else if (in_write) begin
                    if (int'(bus.Base_address) != cap_base || int'(bus.Jump_offset) != cap_jump)
                        stable = 1'b0;
                end
                if (bus.Block_taken) begin
                    takens++;
                    chk("taken_in_write", int'(in_write), 1);
                    chk("addr_hold_stable", int'(stable), 1);
                    in_write = 1'b0;
                end
                if (bus.Frame_done) frames++;
            end
        end
    end

    // Directed stimulus.
    initial begin
        int t;
        int bad;
        int s_base;
        int s_jump;
        int s_pos;
        int t0;

        Reset           = 1'b1;
        writer_on       = 1'b0;
        wd_spur         = 1'b0;
        bus.Enable      = 1'b0;
        bus.Block_ready = 1'b0;

        repeat (3) @(negedge CLOCK_50);
        chk("reset_base",   int'(bus.Base_address), 0);
        chk("reset_jump",   int'(bus.Jump_offset), 160);
        chk("reset_pos",    int'(bus.Plane) + int'(bus.Block_row) + int'(bus.Block_col), 0);
        chk("reset_flags",  int'({bus.Write_start, bus.Block_taken, bus.Frame_done, bus.Busy}), 0);
        Reset     = 1'b0;
        writer_on = 1'b1;
        @(negedge CLOCK_50);

        // ---------------- Frame 1: full frame with a stall in the middle
        push_frame();
        fidx            = 0;
        bus.Block_ready = 1'b1;
        bus.Enable      = 1'b1;
        @(negedge CLOCK_50);
        bus.Enable = 1'b0;
        chk("busy_after_enable", int'(bus.Busy), 1);

        for (t = 0; t < 5000 && !(bus.Block_taken && fidx >= 100); t++) @(negedge CLOCK_50);
        chk("reach_block_100", int'(fidx >= 100), 1);
        bus.Block_ready = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        s_base = int'(bus.Base_address);
        s_jump = int'(bus.Jump_offset);
        s_pos  = int'(bus.Plane) * 4096 + int'(bus.Block_row) * 64 + int'(bus.Block_col);
        t0     = takens;
        bad    = 0;
        for (int i = 0; i < 50; i++) begin
            wd_spur    = (i == 10);
            bus.Enable = (i == 20);
            @(negedge CLOCK_50);
            if (bus.Write_start || bus.Block_taken) bad++;
            if (int'(bus.Base_address) != s_base || int'(bus.Jump_offset) != s_jump) bad++;
            if (int'(bus.Plane) * 4096 + int'(bus.Block_row) * 64 + int'(bus.Block_col) != s_pos) bad++;
            if (!bus.Busy) bad++;
        end
        wd_spur    = 1'b0;
        bus.Enable = 1'b0;
        chk("stall_events", bad, 0);
        chk("stall_no_taken", takens - t0, 0);

        bus.Block_ready = 1'b1;
        @(negedge CLOCK_50);
        chk("resume_start", int'(bus.Write_start), 1);
        wd_spur = 1'b1;
        @(negedge CLOCK_50);
        wd_spur = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.Block_taken) bad++;
            @(negedge CLOCK_50);
        end
        chk("early_done_ignored", bad, 0);

        for (t = 0; t < 60000 && !bus.Frame_done; t++) @(negedge CLOCK_50);
        chk("frame1_done_seen", int'(bus.Frame_done), 1);
        chk("busy_at_frame_done", int'(bus.Busy), 0);
        @(negedge CLOCK_50);
        chk("frame_done_one_cycle", int'(bus.Frame_done), 0);
        chk("busy_after_frame", int'(bus.Busy), 0);
        chk("frame1_starts", starts, 2400);
        chk("frame1_takens", takens, 2400);
        chk("frame1_frames", frames, 1);
        chk("frame1_queue_empty", exp_q.size(), 0);

        // ---------------- Frame 2: reset while block 700 is with the writer
        push_frame();
        fidx       = 0;
        bus.Enable = 1'b1;
        @(negedge CLOCK_50);
        bus.Enable = 1'b0;
        for (t = 0; t < 20000 && fidx < 700; t++) @(negedge CLOCK_50);
        chk("reach_block_700", int'(fidx >= 700), 1);
        repeat (3) @(negedge CLOCK_50);
        Reset     = 1'b1;
        writer_on = 1'b0;
        @(negedge CLOCK_50);
        chk("abort_base",  int'(bus.Base_address), 0);
        chk("abort_jump",  int'(bus.Jump_offset), 160);
        chk("abort_pos",   int'(bus.Plane) + int'(bus.Block_row) + int'(bus.Block_col), 0);
        chk("abort_flags", int'({bus.Write_start, bus.Block_taken, bus.Frame_done, bus.Busy}), 0);
        @(negedge CLOCK_50);
        Reset     = 1'b0;
        writer_on = 1'b1;
        t0  = frames;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLOCK_50);
            if (bus.Frame_done || bus.Block_taken || bus.Write_start || bus.Busy) bad++;
        end
        chk("abort_quiet", bad, 0);
        chk("abort_no_frame_done", frames - t0, 0);

        // ---------------- Frame 3: restart after abort begins at address 0
        push_frame();
        fidx       = 0;
        bus.Enable = 1'b1;
        @(negedge CLOCK_50);
        bus.Enable = 1'b0;
        for (t = 0; t < 500 && fidx < 3; t++) @(negedge CLOCK_50);
        chk("restart_progress", int'(fidx >= 3), 1);
        Reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        exp_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
